// File: rtl/fp_addnorm_pkg.sv
// Shared widths and the stage-1 payload record for the fp_addnorm add/normalise pipeline.
package fp_addnorm_pkg;

  localparam int EXP_W = 3;
  localparam int MAG_W = 3;
  localparam int MAN_W = 2;
  localparam int SUM_W = 4;

  typedef struct packed {
    logic [SUM_W-1:0] sum;
    logic             sign;
    logic [EXP_W-1:0] ex;
  } s1_payload_t;

endpackage

// File: rtl/fp_addnorm_lod4.sv
// Leading-one detector for the 4-bit stage-1 magnitude: index of the top set bit plus a nonzero flag.
module lod4
  import fp_addnorm_pkg::*;
(
  input  logic [SUM_W-1:0] din,
  output logic [1:0]       idx,
  output logic             nz
);

  always_comb begin
    // NOTE: every output gets a default first so no path can leave it unassigned and infer a latch.
    idx = 2'd0;
    if (din[3])      idx = 2'd3;
    else if (din[2]) idx = 2'd2;
    else if (din[1]) idx = 2'd1;
    nz = |din;
  end

endmodule

// File: rtl/fp_addnorm.sv
// Two-stage add/normalise back end of a tiny FP adder: signed magnitude add, then leading-one
// normalise with truncation and flush-to-zero on underflow, valid/ready handshaked at both ends.
module fp_addnorm
  import fp_addnorm_pkg::*;
(
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [EXP_W-1:0] ex,
  input  logic [MAG_W-1:0] mx,
  input  logic [MAG_W-1:0] my,
  input  logic             s,
  input  logic             sx,
  input  logic             sy,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [EXP_W-1:0] e_out,
  output logic [MAN_W-1:0] m_out,
  output logic             s_out,
  output logic             zero_out,
  output logic             unf_sticky
);

  logic             s1_valid_q, s1_valid_d;
  s1_payload_t      s1_q, s1_d;
  logic             s2_valid_q, s2_valid_d;
  logic [EXP_W-1:0] e_q, e_d;
  logic [MAN_W-1:0] m_q, m_d;
  logic             sgn_q, sgn_d;
  logic             zero_q, zero_d;
  logic             unf_q, unf_d;

  logic             s2_load;
  logic             accept;
  logic             sign_x, sign_y;
  s1_payload_t      add_res;
  logic [1:0]       lod_idx;
  logic             lod_nz;
  logic [EXP_W+1:0] e_tmp;
  logic             underflow;

  assign s2_load  = !s2_valid_q || out_ready;
  assign in_ready = !s1_valid_q || s2_load;
  assign accept   = in_valid && in_ready;

  // Stage 1: signed-magnitude add of the aligned pair.
  always_comb begin
    sign_x      = s ? sx : sy;
    sign_y      = s ? sy : sx;
    add_res.ex  = ex;
    add_res.sum = '0;
    add_res.sign = 1'b0;
    if (sign_x == sign_y) begin
      add_res.sum  = {1'b0, mx} + {1'b0, my};
      add_res.sign = sign_x;
    end else if (mx > my) begin
      add_res.sum  = {1'b0, mx} - {1'b0, my};
      add_res.sign = sign_x;
    end else if (my > mx) begin
      add_res.sum  = {1'b0, my} - {1'b0, mx};
      add_res.sign = sign_y;
    end
  end

  lod4 u_lod4 (
    .din (s1_q.sum),
    .idx (lod_idx),
    .nz  (lod_nz)
  );

  // e_tmp is ex + p - 3 held one bit wider so its MSB is the sign.
  assign e_tmp     = {2'b00, s1_q.ex} + {3'b000, lod_idx} - (EXP_W+2)'(3);
  assign underflow = lod_nz && e_tmp[EXP_W+1];

  always_comb begin
    s1_valid_d = s1_valid_q;
    s1_d       = s1_q;
    s2_valid_d = s2_valid_q;
    e_d        = e_q;
    m_d        = m_q;
    sgn_d      = sgn_q;
    zero_d     = zero_q;
    unf_d      = unf_q;

    if (in_ready) s1_valid_d = in_valid;
    if (accept)   s1_d       = add_res;

    if (s2_load) s2_valid_d = s1_valid_q;
    if (s2_load && s1_valid_q) begin
      if (!lod_nz || underflow) begin
        e_d    = '0;
        m_d    = '0;
        sgn_d  = 1'b0;
        zero_d = 1'b1;
        if (underflow) unf_d = 1'b1;
      end else begin
        e_d    = e_tmp[EXP_W-1:0];
        sgn_d  = s1_q.sign;
        zero_d = 1'b0;
        unique case (lod_idx)
          2'd3:    m_d = s1_q.sum[2:1];
          2'd2:    m_d = s1_q.sum[1:0];
          2'd1:    m_d = {s1_q.sum[0], 1'b0};
          default: m_d = 2'b00;
        endcase
      end
    end
  end

  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk) begin
    if (rst) begin
      s1_valid_q <= 1'b0;
      s2_valid_q <= 1'b0;
      e_q        <= '0;
      m_q        <= '0;
      sgn_q      <= 1'b0;
      zero_q     <= 1'b0;
      unf_q      <= 1'b0;
    end else begin
      s1_valid_q <= s1_valid_d;
      s2_valid_q <= s2_valid_d;
      e_q        <= e_d;
      m_q        <= m_d;
      sgn_q      <= sgn_d;
      zero_q     <= zero_d;
      unf_q      <= unf_d;
    end
  end

  // NOTE: the stage-1 payload is qualified by its valid bit, so it needs no reset.
  always_ff @(posedge clk) begin
    s1_q <= s1_d;
  end

  assign out_valid  = s2_valid_q;
  assign e_out      = e_q;
  assign m_out      = m_q;
  assign s_out      = sgn_q;
  assign zero_out   = zero_q;
  assign unf_sticky = unf_q;

endmodule

// File: tb/tb_fp_addnorm.sv
// Directed self-checking bench for fp_addnorm with hand-computed expected results.
module tb_fp_addnorm;

  logic       clk = 1'b0;
  logic       rst;
  logic       in_valid;
  logic       in_ready;
  logic [2:0] ex;
  logic [2:0] mx, my;
  logic       s, sx, sy;
  logic       out_valid;
  logic       out_ready;
  logic [2:0] e_out;
  logic [1:0] m_out;
  logic       s_out;
  logic       zero_out;
  logic       unf_sticky;

  int n_checks = 0;
  int n_errors = 0;

  always #5 clk = ~clk;

  fp_addnorm dut (
    .clk        (clk),
    .rst        (rst),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .ex         (ex),
    .mx         (mx),
    .my         (my),
    .s          (s),
    .sx         (sx),
    .sy         (sy),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .e_out      (e_out),
    .m_out      (m_out),
    .s_out      (s_out),
    .zero_out   (zero_out),
    .unf_sticky (unf_sticky)
  );

  task automatic check(input string tag, input logic [7:0] got, input logic [7:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Result word compared as {e_out, m_out, s_out, zero_out}.
  function automatic logic [7:0] res_word();
    return {1'b0, e_out, m_out, s_out, zero_out};
  endfunction

  function automatic logic [7:0] mk(input logic [2:0] e, input logic [1:0] m,
                                    input logic sg, input logic z);
    return {1'b0, e, m, sg, z};
  endfunction

  // Waits for the next rising edge and steps 1 time unit past it.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic [2:0] e_i, input logic [2:0] mx_i, input logic [2:0] my_i,
                       input logic s_i, input logic sx_i, input logic sy_i);
    in_valid = 1'b1;
    ex = e_i; mx = mx_i; my = my_i; s = s_i; sx = sx_i; sy = sy_i;
  endtask

  // One pair through an idle pipeline with out_ready=1; the result is checked after two edges.
  task automatic run_vec(input string tag,
                         input logic [2:0] e_i, input logic [2:0] mx_i, input logic [2:0] my_i,
                         input logic s_i, input logic sx_i, input logic sy_i,
                         input logic [7:0] exp_res, input logic exp_unf);
    drive(e_i, mx_i, my_i, s_i, sx_i, sy_i);
    tick();
    in_valid = 1'b0;
    tick();
    check({tag, "_valid"}, {7'd0, out_valid}, 8'd1);
    check({tag, "_res"}, res_word(), exp_res);
    check({tag, "_unf"}, {7'd0, unf_sticky}, {7'd0, exp_unf});
    tick();
  endtask

  initial begin
    rst = 1'b1; in_valid = 1'b0; out_ready = 1'b1;
    ex = '0; mx = '0; my = '0; s = 1'b0; sx = 1'b0; sy = 1'b0;
    tick(); tick();
    check("rst_out_valid", {7'd0, out_valid}, 8'd0);
    check("rst_res", res_word(), mk(3'd0, 2'b00, 1'b0, 1'b0));
    check("rst_unf", {7'd0, unf_sticky}, 8'd0);
    rst = 1'b0;
    tick();
    check("rst_in_ready", {7'd0, in_ready}, 8'd1);

    // S=4 -> p=2, e=5+2-3=4, m=S[1:0]=00.
    run_vec("add",    3'd5, 3'd3, 3'd1, 1'b1, 1'b0, 1'b0, mk(3'd4, 2'b00, 1'b0, 1'b0), 1'b0);
    // Equal magnitudes of opposite sign cancel to exact zero, no underflow.
    run_vec("cancel", 3'd4, 3'd3, 3'd3, 1'b1, 1'b0, 1'b1, mk(3'd0, 2'b00, 1'b0, 1'b1), 1'b0);
    // s=0: sign_x=sy=1, sign_y=sx=1 -> S=14, p=3, e=7, m=S[2:1]=11, sign 1.
    run_vec("carry",  3'd7, 3'd7, 3'd7, 1'b0, 1'b1, 1'b1, mk(3'd7, 2'b11, 1'b1, 1'b0), 1'b0);
    // s=0: sign_x=0, sign_y=1, mx>my -> S=3 sign 0, p=1, e=4, m=10.
    run_vec("sub_x",  3'd6, 3'd5, 3'd2, 1'b0, 1'b1, 1'b0, mk(3'd4, 2'b10, 1'b0, 1'b0), 1'b0);
    // s=1: sign_x=0, sign_y=1, my>mx -> S=3 sign 1, e=3+1-3=1, m=10.
    run_vec("sub_y",  3'd3, 3'd2, 3'd5, 1'b1, 1'b0, 1'b1, mk(3'd1, 2'b10, 1'b1, 1'b0), 1'b0);
    // e_tmp lands exactly on 0: S=1, p=0, e=3+0-3=0, not flushed.
    run_vec("e_zero", 3'd3, 3'd1, 3'd0, 1'b1, 1'b0, 1'b0, mk(3'd0, 2'b00, 1'b0, 1'b0), 1'b0);
    // S=1, e_tmp=1+0-3=-2 -> flush, sticky set.
    run_vec("unf",    3'd1, 3'd1, 3'd0, 1'b1, 1'b1, 1'b0, mk(3'd0, 2'b00, 1'b0, 1'b1), 1'b1);
    // Normal result after the flush keeps the sticky bit.
    run_vec("post_unf", 3'd5, 3'd3, 3'd1, 1'b1, 1'b0, 1'b0, mk(3'd4, 2'b00, 1'b0, 1'b0), 1'b1);

    // Backpressure: A, B, C back to back with out_ready held low.
    out_ready = 1'b0;
    drive(3'd5, 3'd3, 3'd1, 1'b1, 1'b0, 1'b0);          // A -> e4 m00 s0
    check("bp_rdy_a", {7'd0, in_ready}, 8'd1);
    tick();
    drive(3'd6, 3'd5, 3'd2, 1'b0, 1'b1, 1'b0);          // B -> e4 m10 s0
    check("bp_rdy_b", {7'd0, in_ready}, 8'd1);
    tick();
    drive(3'd7, 3'd7, 3'd7, 1'b0, 1'b1, 1'b1);          // C -> e7 m11 s1
    check("bp_rdy_drop", {7'd0, in_ready}, 8'd0);
    for (int i = 0; i < 4; i++) begin
      check($sformatf("bp_hold_valid%0d", i), {7'd0, out_valid}, 8'd1);
      check($sformatf("bp_hold_res%0d", i), res_word(), mk(3'd4, 2'b00, 1'b0, 1'b0));
      if (i < 3) begin
        check($sformatf("bp_hold_rdy%0d", i), {7'd0, in_ready}, 8'd0);
        tick();
      end
    end
    out_ready = 1'b1;
    #1;
    check("bp_rdy_release", {7'd0, in_ready}, 8'd1);
    tick();
    in_valid = 1'b0;
    check("bp_out_b_valid", {7'd0, out_valid}, 8'd1);
    check("bp_out_b", res_word(), mk(3'd4, 2'b10, 1'b0, 1'b0));
    tick();
    check("bp_out_c_valid", {7'd0, out_valid}, 8'd1);
    check("bp_out_c", res_word(), mk(3'd7, 2'b11, 1'b1, 1'b0));
    tick();
    check("bp_drained", {7'd0, out_valid}, 8'd0);

    // Reset mid-stream with both stages full and the sticky bit still set.
    check("mid_unf_before", {7'd0, unf_sticky}, 8'd1);
    out_ready = 1'b0;
    drive(3'd7, 3'd7, 3'd7, 1'b0, 1'b1, 1'b1);
    tick();
    drive(3'd6, 3'd5, 3'd2, 1'b0, 1'b1, 1'b0);
    tick();
    in_valid = 1'b0;
    check("mid_full", {7'd0, out_valid}, 8'd1);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    out_ready = 1'b1;
    check("mid_out_valid", {7'd0, out_valid}, 8'd0);
    check("mid_unf", {7'd0, unf_sticky}, 8'd0);
    check("mid_res", res_word(), mk(3'd0, 2'b00, 1'b0, 1'b0));
    check("mid_in_ready", {7'd0, in_ready}, 8'd1);
    for (int i = 0; i < 4; i++) begin
      tick();
      check($sformatf("mid_no_stale%0d", i), {7'd0, out_valid}, 8'd0);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_checks, n_errors);
    $finish;
  end

endmodule
